cpu_read_sequencer: RTL
=======================

# cpu_read_sequencer

Controls the Z80 CPU data-input mux. After reset it jams a `JP RESET_VECTOR` instruction onto the bus by sequencing the `c3En_cs`, `ladrEn_cs` and `hadrEn_cs` selects across the CPU's first three memory reads. It then hands off to normal decode. In normal operation it also stretches read cycles that target slow devices by requesting Z80 wait states. It sits between the synchronized Z80 bus-control pins and the data-in mux select and `rstAdr` inputs.

## Interface
- `RESET_VECTOR`, default 16'hF000: jump target presented on `rstAdr`.
- `WAIT_CLKS`, default 8: number of `pll0_250MHz` clocks that `waitReq` is held per slow read. Legal range is 1–255.
- `pll0_250MHz` input 1: sole clock.
- `reset` input 1: synchronous, active-high reset.
- `z80_rd_n` input 1: Z80 RD pin, asynchronous and active low.
- `z80_mreq_n` input 1: Z80 MREQ pin, asynchronous and active low.
- `z80_iorq_n` input 1: Z80 IORQ pin, asynchronous and active low.
- `slowDev_cs` input 1: address-decode flag marking the current access as a slow device. Sampled at read start.
- `rejam` input 1: single-clock pulse requesting a new jump-vector sequence without a full reset.
- `rstAdr` output 16: constant `RESET_VECTOR`, registered.
- `reset_cs` output 1: high while a jam sequence is pending or in progress.
- `c3En_cs` output 1: selects the 8'hC3 opcode.
- `ladrEn_cs` output 1: selects `rstAdr[7:0]`.
- `hadrEn_cs` output 1: selects `rstAdr[15:8]`.
- `waitReq` output 1: active-high request to drive Z80 WAIT_n low.
- `jamDone` output 1: single-clock pulse when the sequence completes.

## Operation
- Synchronizer:
  - `z80_rd_n`, `z80_mreq_n` and `z80_iorq_n` each pass through a 2-flop synchronizer.
  - `memRd` = synced ~rd & ~mreq.
  - `ioRd` = synced ~rd & ~iorq.
  - `rdStart` = rising edge of (`memRd` | `ioRd`).
  - `rdEnd` = falling edge of (`memRd` | `ioRd`).
- Jam FSM states: `J_OP`, `J_LO`, `J_HI`, `RUN`. Reset enters `J_OP`.
- `J_OP`:
  - On a `memRd` `rdStart`, assert `c3En_cs`.
  - Hold `c3En_cs` until `rdEnd`, then go to `J_LO`.
  - An `ioRd` does not advance the FSM and asserts no select.
- `J_LO`: same behaviour using `ladrEn_cs`, then go to `J_HI`.
- `J_HI`:
  - Same behaviour using `hadrEn_cs`.
  - On `rdEnd`, go to `RUN` and pulse `jamDone`.
- `RUN`:
  - All three jam selects are low and `reset_cs` is low.
  - `rejam` sets a pending flag. `reset_cs` goes high on the next clock.
  - If no read is active, the FSM enters `J_OP` on the next clock.
  - If a read is active, the FSM enters `J_OP` on that read's `rdEnd`. The in-flight read is never jammed.
- `reset_cs` = (state != `RUN`) | pending.
- At most one of `c3En_cs`, `ladrEn_cs` and `hadrEn_cs` is high in any clock.
- Wait-state generator (any state):
  - On `rdStart` with `slowDev_cs`=1, load the counter with `WAIT_CLKS` and assert `waitReq`.
  - Decrement the counter each clock. Deassert `waitReq` when it reaches 0.
  - The counter is not retriggered until `rdEnd`.
  - `rdEnd` while counting clears the counter and `waitReq` immediately.
  - Jam reads ignore `slowDev_cs` and never wait.
- Reset mid-operation:
  - All outputs return to their reset values on the next clock.
  - The FSM restarts at `J_OP` and waits for a fresh `rdStart`. A read already in progress is not jammed.

## Timing
- Reset values:
  - `reset_cs`=1.
  - `c3En_cs`, `ladrEn_cs`, `hadrEn_cs`, `waitReq` and `jamDone` = 0.
  - `rstAdr`=`RESET_VECTOR`.
  - Counter = 0, pending = 0.
- Pin-to-detect latency: a pin edge sets `rdStart`/`rdEnd` 3 clocks later (2 sync flops plus the edge register).
- Select assertion is registered. It rises the clock after `rdStart` and falls the clock after `rdEnd`.
  - Total pin-to-select latency is 4 clocks (16 ns).
  - The registered mux adds 1 more clock, giving 20 ns. This is well inside the Z80 RD-to-data window.
- `waitReq` rises the clock after `rdStart`. It is high for exactly `WAIT_CLKS` clocks unless the read ends first.
- `jamDone` is high for exactly 1 clock, coincident with the `hadrEn_cs` fall.
- If `rejam` coincides with `reset`, `reset` wins.
- A `rejam` during a jam sequence is ignored.

## Test plan
- Reset, then three memory reads of 100 ns each:
  - `c3En_cs`, then `ladrEn_cs`, then `hadrEn_cs` are each high for the duration of their read, +4 clocks.
  - `jamDone` pulses once and `reset_cs` drops with it.
  - `rstAdr`=16'hF000 throughout.
- After reset, an I/O read precedes the first memory read: no select asserts during the I/O read, and the FSM stays in `J_OP`.
- In `RUN`, an I/O read with `slowDev_cs`=1 and `WAIT_CLKS`=8:
  - `waitReq` is high for exactly 8 clocks, starting 4 clocks after the RD fall.
  - A second read without `slowDev_cs` produces no wait.
- A slow read that ends after 3 clocks of `waitReq`: `waitReq` clears within 1 clock of `rdEnd`, and the counter reads 0.
- `rejam` pulsed mid-read in `RUN`:
  - `reset_cs` rises the next clock.
  - The current read gets no jam select.
  - The next three memory reads get C3/lo/hi.
- `reset` asserted while `ladrEn_cs` is high:
  - All selects drop the next clock.
  - The next memory read gets `c3En_cs`.

Source files
------------

// File: rtl/cpu_read_sequencer.sv
// Z80 data-in mux sequencer: jams JP RESET_VECTOR over the first three memory reads
// after reset or rejam, and stretches slow-device reads with wait states.
module cpu_read_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'hF000,
    parameter int unsigned WAIT_CLKS    = 8
) (
    input  logic        pll0_250MHz,
    input  logic        reset,
    input  logic        z80_rd_n,
    input  logic        z80_mreq_n,
    input  logic        z80_iorq_n,
    input  logic        slowDev_cs,
    input  logic        rejam,
    output logic [15:0] rstAdr,
    output logic        reset_cs,
    output logic        c3En_cs,
    output logic        ladrEn_cs,
    output logic        hadrEn_cs,
    output logic        waitReq,
    output logic        jamDone
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SYNC_W = 2;

    typedef enum logic [1:0] {J_OP, J_LO, J_HI, RUN} jam_state_e;

    logic [SYNC_W-1:0] rd_sync_q,   rd_sync_d;
    logic [SYNC_W-1:0] mreq_sync_q, mreq_sync_d;
    logic [SYNC_W-1:0] iorq_sync_q, iorq_sync_d;

    logic              act_q,      act_d;
    logic              rd_start_q, rd_start_d;
    logic              rd_end_q,   rd_end_d;
    logic              rd_mem_q,   rd_mem_d;
    jam_state_e        state_q,    state_d;
    logic              jam_q,      jam_d;
    logic              pend_q,     pend_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              wait_q,     wait_d;
    logic              done_q,     done_d;
    logic              c3_q,       c3_d;
    logic              lo_q,       lo_d;
    logic              hi_q,       hi_d;
    logic              reset_cs_q, reset_cs_d;
    logic [15:0]       rst_adr_q,  rst_adr_d;

    logic mem_rd_c;
    logic io_rd_c;
    logic rd_act_c;
    logic rd_busy_c;
    logic jam_rd_c;

    // Synchronizers are left unreset so a read in flight across reset stays visible.
    always_ff @(posedge pll0_250MHz) begin
        rd_sync_q   <= rd_sync_d;
        mreq_sync_q <= mreq_sync_d;
        iorq_sync_q <= iorq_sync_d;
    end

    always_comb begin
        rd_sync_d   = {rd_sync_q[0],   z80_rd_n};
        mreq_sync_d = {mreq_sync_q[0], z80_mreq_n};
        iorq_sync_d = {iorq_sync_q[0], z80_iorq_n};

        mem_rd_c  = ~rd_sync_q[1] & ~mreq_sync_q[1];
        io_rd_c   = ~rd_sync_q[1] & ~iorq_sync_q[1];
        rd_act_c  = mem_rd_c | io_rd_c;
        rd_busy_c = rd_act_c | act_q;
        jam_rd_c  = rd_start_q & rd_mem_q & (state_q != RUN);

        act_d      = rd_act_c;
        rd_start_d = rd_act_c & ~act_q;
        rd_end_d   = ~rd_act_c & act_q;
        rd_mem_d   = mem_rd_c;

        state_d   = state_q;
        jam_d     = jam_q;
        pend_d    = pend_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        rst_adr_d = RESET_VECTOR;

        // Jam sequencing; rejam is only honoured once the sequence has finished.
        case (state_q)
            RUN: begin
                if (rejam) begin
                    pend_d = 1'b1;
                end
                if (pend_d && !rd_busy_c) begin
                    state_d = J_OP;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                if (!jam_q && rd_start_q && rd_mem_q) begin
                    jam_d = 1'b1;
                end else if (jam_q && rd_end_q) begin
                    jam_d   = 1'b0;
                    done_d  = (state_q == J_HI);
                    state_d = (state_q == J_OP) ? J_LO :
                              (state_q == J_LO) ? J_HI : RUN;
                end
            end
        endcase

        // Wait-state counter; jammed reads never wait.
        if (rd_start_q && slowDev_cs && !jam_rd_c) begin
            cnt_d = CNT_W'(WAIT_CLKS);
        end else if (rd_end_q) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        wait_d     = (cnt_d != '0);
        c3_d       = jam_d && (state_d == J_OP);
        lo_d       = jam_d && (state_d == J_LO);
        hi_d       = jam_d && (state_d == J_HI);
        reset_cs_d = (state_d != RUN) || pend_d;
    end

    // Edge detect starts "busy" so a read spanning reset produces no fresh start.
    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            act_q      <= 1'b1;
            rd_start_q <= 1'b0;
            rd_end_q   <= 1'b0;
            rd_mem_q   <= 1'b0;
            state_q    <= J_OP;
            jam_q      <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            wait_q     <= 1'b0;
            done_q     <= 1'b0;
            c3_q       <= 1'b0;
            lo_q       <= 1'b0;
            hi_q       <= 1'b0;
            reset_cs_q <= 1'b1;
            rst_adr_q  <= RESET_VECTOR;
        end else begin
            act_q      <= act_d;
            rd_start_q <= rd_start_d;
            rd_end_q   <= rd_end_d;
            rd_mem_q   <= rd_mem_d;
            state_q    <= state_d;
            jam_q      <= jam_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            c3_q       <= c3_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            reset_cs_q <= reset_cs_d;
            rst_adr_q  <= rst_adr_d;
        end
    end

    assign rstAdr    = rst_adr_q;
    assign reset_cs  = reset_cs_q;
    assign c3En_cs   = c3_q;
    assign ladrEn_cs = lo_q;
    assign hadrEn_cs = hi_q;
    assign waitReq   = wait_q;
    assign jamDone   = done_q;

endmodule
